// File: rtl/pc_unit.sv
// Program counter stage: holds the PC, supplies PC+1 for jump-and-link, and
// updates by increment, conditional relative branch or absolute jump under an IDLE/RUN/HALT gate.
module pc_unit #(
   parameter int             W         = 16,
   parameter int             AD_W      = 6,
   parameter logic [W-1:0]   RESET_VEC = 16'h0000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            halt_req,
   input  logic            PI,
   input  logic            PL,
   input  logic            JB,
   input  logic [2:0]      BC,
   input  logic            Z,
   input  logic            N,
   input  logic            C,
   input  logic            V,
   input  logic [W-1:0]    bus_a,
   input  logic [AD_W-1:0] ad,
   output logic [W-1:0]    pc,
   output logic [W-1:0]    pc_1,
   output logic            running,
   output logic            halted,
   output logic            branch_taken
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      HALT = 2'b10
   } state_t;

   state_t         state_r;
   logic [W-1:0]   pc_r;
   logic           running_r;
   logic           halted_r;
   logic           branch_taken_r;

   logic [W-1:0]   pc_1_s;
   logic [W-1:0]   ad_ext_s;
   logic [W-1:0]   br_target_s;
   logic           cond_s;

   function automatic logic cond_eval(input logic [2:0] bc, input logic z, input logic n,
                                      input logic c, input logic v);
      logic res;
      case (bc)
         3'b000:  res = 1'b1;
         3'b001:  res = z;
         3'b010:  res = n;
         3'b011:  res = c;
         3'b100:  res = v;
         3'b101:  res = ~z;
         3'b110:  res = ~n;
         3'b111:  res = 1'b0;
         default: res = 1'b0;
      endcase
      return res;
   endfunction

   // Increment, sign-extended displacement and branch target; all wrap modulo 2^W.
   always_comb begin
      pc_1_s      = pc_r + {{(W-1){1'b0}}, 1'b1};
      ad_ext_s    = {{(W-AD_W){ad[AD_W-1]}}, ad};
      br_target_s = pc_1_s + ad_ext_s;
      cond_s      = cond_eval(BC, Z, N, C, V);
   end

   // Run-control FSM and PC register; halt_req outranks PL, which outranks PI.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r        <= IDLE;
         pc_r           <= RESET_VEC;
         running_r      <= 1'b0;
         halted_r       <= 1'b0;
         branch_taken_r <= 1'b0;
      end else begin
         branch_taken_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start) begin
                  state_r   <= RUN;
                  running_r <= 1'b1;
                  halted_r  <= 1'b0;
               end else begin
                  running_r <= 1'b0;
                  halted_r  <= 1'b0;
               end
            end
            RUN: begin
               if (halt_req) begin
                  state_r   <= HALT;
                  running_r <= 1'b0;
                  halted_r  <= 1'b1;
               end else begin
                  running_r <= 1'b1;
                  halted_r  <= 1'b0;
                  if (PL) begin
                     if (JB) begin
                        pc_r           <= bus_a;
                        branch_taken_r <= 1'b1;
                     end else if (cond_s) begin
                        pc_r           <= br_target_s;
                        branch_taken_r <= 1'b1;
                     end else begin
                        pc_r <= pc_1_s;
                     end
                  end else if (PI) begin
                     pc_r <= pc_1_s;
                  end else begin
                     pc_r <= pc_r;
                  end
               end
            end
            HALT: begin
               if (start) begin
                  state_r   <= RUN;
                  running_r <= 1'b1;
                  halted_r  <= 1'b0;
               end else begin
                  running_r <= 1'b0;
                  halted_r  <= 1'b1;
               end
            end
            default: begin
               state_r   <= IDLE;
               running_r <= 1'b0;
               halted_r  <= 1'b0;
            end
         endcase
      end
   end

   assign pc           = pc_r;
   assign pc_1         = pc_1_s;
   assign running      = running_r;
   assign halted       = halted_r;
   assign branch_taken = branch_taken_r;

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Program counter stage of the RISC datapath.
- Holds the 16-bit PC and supplies pc_1 (PC+1) to the Bus A multiplexer, which uses it for jump-and-link.
- Updates the PC by increment, by conditional PC-relative branch, or by absolute jump from Bus A, under control-word bits and ALU status flags.
- Contains a small run-control FSM (IDLE/RUN/HALT) that gates all PC updates.

Parameters:
- W, 16, PC and bus width in bits.
- AD_W, 6, branch displacement width (two's complement).
- RESET_VEC, 16'h0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  leave IDLE or HALT and enter RUN.
- halt_req  input  1  request transition to HALT.
- PI  input  1  increment PC.
- PL  input  1  load PC (branch or jump).
- JB  input  1  1 = jump (PC <= bus_a); 0 = conditional branch.
- BC  input  3  branch condition select.
- Z, N, C, V  input  1 each  ALU status flags, sampled in the same cycle as PL.
- bus_a  input  W  jump target from Bus A.
- ad  input  AD_W  signed branch displacement.
- pc  output  W  current PC, registered.
- pc_1  output  W  pc+1 mod 2^W, combinational from the pc register.
- running  output  1  FSM is in RUN.
- halted  output  1  FSM is in HALT.
- branch_taken  output  1  registered one-cycle pulse when PC was loaded via PL.

Behaviour:
- Reset (asynchronous, any time, including mid-update):
  - pc = RESET_VEC, FSM = IDLE.
  - running = 0, halted = 0, branch_taken = 0.
  - pc_1 = RESET_VEC+1.
- FSM:
  - IDLE: start=1 -> RUN on the next edge. PI, PL and halt_req are ignored; PC holds.
  - RUN: halt_req=1 -> HALT; otherwise stay in RUN.
  - HALT: PC frozen. start=1 -> RUN; the PC resumes from its held value (not reset). halt_req is ignored.
- PC update, only in RUN, in priority order per edge:
  - 1. halt_req=1: PC holds and the FSM enters HALT. halt_req wins over PL and PI in the same cycle.
  - 2. PL=1, JB=1: pc <= bus_a; branch_taken=1 next cycle.
  - 3. PL=1, JB=0, condition true: pc <= pc_1 + sign_extend(ad), mod 2^W; branch_taken=1.
  - 4. PL=1, JB=0, condition false: pc <= pc_1 (fall-through); branch_taken=0.
  - 5. PI=1 (PL=0): pc <= pc_1.
  - 6. Otherwise: hold.
- PL with PI asserted together: PL wins. PI is not added on top.
- BC encoding:
  - 000 always, 001 Z, 010 N, 011 C, 100 V.
  - 101 !Z, 110 !N, 111 never.
  - Conditions are evaluated on the flag values present in the cycle PL is sampled.
- Arithmetic:
  - All additions are modulo 2^W.
  - 16'hFFFF + 1 = 16'h0000.
  - A negative displacement wraps below 0; e.g. pc_1 = 0, ad = -1 gives 16'hFFFF.
- Latency:
  - PC changes one clock after the control inputs are sampled.
  - pc_1 follows pc combinationally.
  - branch_taken is high for exactly the cycle in which the new PC is visible.
- running and halted are registered, decoded from the FSM state, and mutually exclusive.
- Unknown or illegal FSM encodings return to IDLE.

Test Plan:
- Reset, then release rst_n, start pulse, PI=1 for 3 cycles -> pc steps 0,1,2,3; pc_1 = pc+1 each cycle; running=1.
- In RUN with pc=16'h0010, PL=1, JB=1, bus_a=16'h1234 -> pc=16'h1234 next cycle; branch_taken=1 for one cycle; pc_1=16'h1235.
- pc=16'h0020, PL=1, JB=0, BC=001, ad=6'b111100 (-4):
  - Z=1 -> pc=16'h001D, branch_taken=1.
  - Repeat with Z=0 -> pc=16'h0021, branch_taken=0.
- pc=16'hFFFF, PI=1 -> pc=16'h0000, pc_1=16'h0001. Separately, pc=0 with an always-branch (BC=000) and ad=-2 -> pc=16'hFFFF.
- halt_req=1 together with PL=1 -> halted=1, pc unchanged. PI/PL held high in HALT -> pc stays frozen. start -> running=1 and increments resume from the held pc.
- Assert rst_n=0 asynchronously mid-cycle during a jump -> pc=RESET_VEC and IDLE immediately, without waiting for a clock edge; PI=1 in IDLE leaves pc unchanged.
